// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtag_pkg
// Brief   : TAP controller state encoding shared by the FSM and the datapath.
// Revision: 1.0 - initial release
// ============================================================================
package jtag_pkg;

  localparam logic [3:0] TLR   = 4'd0;
  localparam logic [3:0] RTI   = 4'd1;
  localparam logic [3:0] SELDR = 4'd2;
  localparam logic [3:0] CAPDR = 4'd3;
  localparam logic [3:0] SHDR  = 4'd4;
  localparam logic [3:0] EX1DR = 4'd5;
  localparam logic [3:0] PDR   = 4'd6;
  localparam logic [3:0] EX2DR = 4'd7;
  localparam logic [3:0] UPDR  = 4'd8;
  localparam logic [3:0] SELIR = 4'd9;
  localparam logic [3:0] CAPIR = 4'd10;
  localparam logic [3:0] SHIR  = 4'd11;
  localparam logic [3:0] EX1IR = 4'd12;
  localparam logic [3:0] PIR   = 4'd13;
  localparam logic [3:0] EX2IR = 4'd14;
  localparam logic [3:0] UPIR  = 4'd15;

  function automatic logic is_shift_state(input logic [3:0] state);
    return (state == SHDR) || (state == SHIR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module  : jtag_tap_fsm
// Brief   : 16-state IEEE 1149.1 TAP controller, advanced by TMS on TCK rise.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_tap_fsm (
  input  logic       TCK,
  input  logic       Reset,
  input  logic       TMS,
  output logic [3:0] tap_state
);
  import jtag_pkg::*;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge TCK) begin
    if (Reset) r_state <= TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = TMS ? TLR   : RTI;
      RTI:     w_next = TMS ? SELDR : RTI;
      SELDR:   w_next = TMS ? SELIR : CAPDR;
      CAPDR:   w_next = TMS ? EX1DR : SHDR;
      SHDR:    w_next = TMS ? EX1DR : SHDR;
      EX1DR:   w_next = TMS ? UPDR  : PDR;
      PDR:     w_next = TMS ? EX2DR : PDR;
      EX2DR:   w_next = TMS ? UPDR  : SHDR;
      UPDR:    w_next = TMS ? SELDR : RTI;
      SELIR:   w_next = TMS ? TLR   : CAPIR;
      CAPIR:   w_next = TMS ? EX1IR : SHIR;
      SHIR:    w_next = TMS ? EX1IR : SHIR;
      EX1IR:   w_next = TMS ? UPIR  : PIR;
      PIR:     w_next = TMS ? EX2IR : PIR;
      EX2IR:   w_next = TMS ? UPIR  : SHIR;
      UPIR:    w_next = TMS ? SELDR : RTI;
      default: w_next = TLR;
    endcase
  end

  always_comb begin
    tap_state = r_state;
  end

endmodule
`default_nettype wire

// File: rtl/jtag_tap_core.sv
`default_nettype none
// ============================================================================
// Module  : jtag_tap_core
// Brief   : JTAG TAP with IR, bypass, optional IDCODE and a USER data register.
//           Macro JTAG_TAP_IDCODE_EN adds the ID register and makes IDCODE the
//           reset instruction; otherwise the reset instruction is BYPASS.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_tap_core #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter int unsigned          DR_WIDTH   = 32,
  parameter logic [31:0]          IDCODE_VAL = 32'h1234_5001,
  parameter logic [IR_WIDTH-1:0]  OPC_IDCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  OPC_USER   = IR_WIDTH'(2)
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_update
);
  import jtag_pkg::*;

  localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(1);

  if (!IDCODE_VAL[0] || (OPC_IDCODE == OPC_USER) || (IR_WIDTH < 2) || (DR_WIDTH < 1)) begin : g_cfg_check
    $error("jtag_tap_core: invalid parameter set");
  end

  logic [3:0]          w_state;
  logic                w_sel_id;
  logic                w_sel_user;
  logic                w_sel_bypass;
  logic                w_id_tdo;
  logic                w_to_upir;
  logic                w_to_updr;
  logic                w_to_tlr;
  logic                w_tdo;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir_out;
  logic [DR_WIDTH-1:0] r_user_sr;
  logic [DR_WIDTH-1:0] r_user_dr_out;
  logic                r_user_update;
  logic                r_bypass;

  jtag_tap_fsm u_fsm (
    .TCK       (TCK),
    .Reset     (Reset),
    .TMS       (TMS),
    .tap_state (w_state)
  );

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] c_reset_opc = OPC_IDCODE;
  logic [31:0] r_id_sr;

  assign w_sel_id = (r_ir_out == OPC_IDCODE);
  assign w_id_tdo = r_id_sr[0];

  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_id_sr <= '0;
    end else if (w_sel_id) begin
      if (w_state == CAPDR)     r_id_sr <= IDCODE_VAL;
      else if (w_state == SHDR) r_id_sr <= {TDI, r_id_sr[31:1]};
    end
  end
`else
  localparam logic [IR_WIDTH-1:0] c_reset_opc = '1;

  assign w_sel_id = 1'b0;
  assign w_id_tdo = 1'b0;
`endif

  assign w_sel_user   = (r_ir_out == OPC_USER) && !w_sel_id;
  assign w_sel_bypass = !w_sel_id && !w_sel_user;

  // Next-state decodes: updates happen on the edge that enters the Update state.
  assign w_to_upir = ((w_state == EX1IR) || (w_state == EX2IR)) && TMS;
  assign w_to_updr = ((w_state == EX1DR) || (w_state == EX2DR)) && TMS;
  assign w_to_tlr  = ((w_state == SELIR) || (w_state == TLR)) && TMS;

  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_ir_sr  <= '0;
      r_ir_out <= c_reset_opc;
    end else begin
      if (w_state == CAPIR)     r_ir_sr <= c_ir_capture;
      else if (w_state == SHIR) r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};

      if (w_to_tlr)       r_ir_out <= c_reset_opc;
      else if (w_to_upir) r_ir_out <= r_ir_sr;
    end
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_user_sr     <= '0;
      r_user_dr_out <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= w_to_updr && w_sel_user;
      if (w_sel_user) begin
        if (w_state == CAPDR)     r_user_sr <= user_dr_in;
        else if (w_state == SHDR) r_user_sr <= (r_user_sr >> 1) | (DR_WIDTH'(TDI) << (DR_WIDTH - 1));
        if (w_to_updr)            r_user_dr_out <= r_user_sr;
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_bypass <= 1'b0;
    end else if (w_sel_bypass) begin
      if (w_state == CAPDR)     r_bypass <= 1'b0;
      else if (w_state == SHDR) r_bypass <= TDI;
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (w_state == SHIR)     w_tdo = r_ir_sr[0];
    else if (w_state == SHDR) begin
      if (w_sel_id)          w_tdo = w_id_tdo;
      else if (w_sel_user)   w_tdo = r_user_sr[0];
      else                   w_tdo = r_bypass;
    end
  end

  assign TDO         = w_tdo;
  assign tdo_en      = is_shift_state(w_state);
  assign tap_state   = w_state;
  assign ir_out      = r_ir_out;
  assign user_dr_out = r_user_dr_out;
  assign user_update = r_user_update;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_jtag_tap_core
// Brief   : Directed self-checking bench for jtag_tap_core (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_jtag_tap_core;
  import jtag_pkg::*;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] c_reset_opc = 4'b0001;
`else
  localparam logic [3:0] c_reset_opc = 4'b1111;
`endif

  logic        TCK = 1'b0;
  logic        Reset;
  logic        TMS;
  logic        TDI;
  logic        TDO;
  logic        tdo_en;
  logic [3:0]  tap_state;
  logic [3:0]  ir_out;
  logic [31:0] user_dr_in;
  logic [31:0] user_dr_out;
  logic        user_update;

  int checks    = 0;
  int failures  = 0;
  int pulse_cnt = 0;

  jtag_tap_core dut (
    .TCK         (TCK),
    .Reset       (Reset),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .tdo_en      (tdo_en),
    .tap_state   (tap_state),
    .ir_out      (ir_out),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update)
  );

  always #5 TCK = ~TCK;

  always @(negedge TCK) begin
    if (user_update === 1'b1) pulse_cnt++;
  end

  typedef struct {
    logic       tms;
    logic [3:0] st;
  } vec_t;

  vec_t walk [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = TDO;
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  cap;
    logic [31:0] dout;
    logic [31:0] din;
    int          p0;
    logic        exp_en;

    walk[0]  = '{1'b0, RTI};   walk[1]  = '{1'b1, SELDR}; walk[2]  = '{1'b0, CAPDR};
    walk[3]  = '{1'b0, SHDR};  walk[4]  = '{1'b1, EX1DR}; walk[5]  = '{1'b0, PDR};
    walk[6]  = '{1'b1, EX2DR}; walk[7]  = '{1'b0, SHDR};  walk[8]  = '{1'b1, EX1DR};
    walk[9]  = '{1'b1, UPDR};  walk[10] = '{1'b1, SELDR}; walk[11] = '{1'b1, SELIR};
    walk[12] = '{1'b0, CAPIR}; walk[13] = '{1'b0, SHIR};  walk[14] = '{1'b1, EX1IR};
    walk[15] = '{1'b0, PIR};   walk[16] = '{1'b1, EX2IR}; walk[17] = '{1'b0, SHIR};
    walk[18] = '{1'b1, EX1IR}; walk[19] = '{1'b1, UPIR};  walk[20] = '{1'b0, RTI};
    walk[21] = '{1'b1, SELDR}; walk[22] = '{1'b1, SELIR}; walk[23] = '{1'b1, TLR};
    walk[24] = '{1'b1, TLR};   walk[25] = '{1'b0, RTI};

    // Reset held with TMS=1 to show Reset wins.
    Reset = 1'b1; TMS = 1'b1; TDI = 1'b0; user_dr_in = '0;
    repeat (2) @(posedge TCK);
    #1;
    chk("rst_state", 32'(tap_state), 32'(TLR));
    chk("rst_ir_out", 32'(ir_out), 32'(c_reset_opc));
    chk("rst_user_dr_out", user_dr_out, 32'h0);
    chk("rst_user_update", 32'(user_update), 32'h0);
    chk("rst_tdo_en", 32'(tdo_en), 32'h0);
    chk("rst_tdo", 32'(TDO), 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(walk[i].tms, 1'b0);
      exp_en = (walk[i].st == SHDR) || (walk[i].st == SHIR);
      chk($sformatf("walk_state[%0d]", i), 32'(tap_state), 32'(walk[i].st));
      chk($sformatf("walk_tdo_en[%0d]", i), 32'(tdo_en), 32'(exp_en));
      if (!exp_en) chk($sformatf("walk_tdo[%0d]", i), 32'(TDO), 32'h0);
    end
    chk("walk_ir_out", 32'(ir_out), 32'(c_reset_opc));
    chk("walk_pulses", pulse_cnt, 0);

    scan_ir(4'b0010, cap);
    chk("ir_capture", 32'(cap), 32'h1);
    chk("ir_out_user", 32'(ir_out), 32'h2);
    chk("ir_scan_state", 32'(tap_state), 32'(RTI));

    user_dr_in = 32'hCAFE_F00D;
    p0 = pulse_cnt;
    scan_dr(32, 32'hA5A5_0F0F, dout);
    chk("user_tdo", dout, 32'hCAFE_F00D);
    chk("user_dr_out", user_dr_out, 32'hA5A5_0F0F);
    chk("user_pulse", pulse_cnt - p0, 1);

    // Shift half, park in Pause-DR with TDI=1, resume via Exit2-DR.
    user_dr_in = 32'h1357_9BDF;
    din = 32'h0F1E_2D3C;
    dout = '0;
    p0 = pulse_cnt;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      dout[i] = TDO;
      step(i == 15, din[i]);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pause_state", 32'(tap_state), 32'(PDR));
    chk("pause_tdo_en", 32'(tdo_en), 32'h0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("exit2_state", 32'(tap_state), 32'(EX2DR));
    step(1'b0, 1'b1);
    for (int i = 16; i < 32; i++) begin
      dout[i] = TDO;
      step(i == 31, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_tdo", dout, 32'h1357_9BDF);
    chk("pause_user_dr_out", user_dr_out, 32'h0F1E_2D3C);
    chk("pause_pulse", pulse_cnt - p0, 1);

    scan_ir(4'b0001, cap);
    p0 = pulse_cnt;
`ifdef JTAG_TAP_IDCODE_EN
    scan_dr(32, 32'h0, dout);
    chk("idcode_tdo", dout, 32'h1234_5001);
`else
    scan_dr(4, 32'hD, dout);
    chk("idcode_as_bypass_tdo", dout, 32'hA);
`endif
    chk("idcode_pulse", pulse_cnt - p0, 0);
    chk("idcode_user_dr_out", user_dr_out, 32'h0F1E_2D3C);

    // Bypass: TDI 1,0,1,1 -> TDO 0,1,0,1.
    scan_ir(4'b1111, cap);
    p0 = pulse_cnt;
    scan_dr(4, 32'hD, dout);
    chk("bypass_tdo", dout, 32'hA);
    chk("bypass_pulse", pulse_cnt - p0, 0);

    scan_ir(4'b0000, cap);
    chk("ir_out_zero", 32'(ir_out), 32'h0);
    p0 = pulse_cnt;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    chk("escape_state", 32'(tap_state), 32'(TLR));
    chk("escape_ir_out", 32'(ir_out), 32'(c_reset_opc));
    chk("escape_user_dr_out", user_dr_out, 32'h0F1E_2D3C);
    chk("escape_pulse", pulse_cnt - p0, 0);

    // Reset in the middle of a USER shift must abort with no update.
    step(1'b0, 1'b0);
    scan_ir(4'b0010, cap);
    chk("ir_out_user2", 32'(ir_out), 32'h2);
    p0 = pulse_cnt;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    Reset = 1'b1;
    TMS = 1'b1;
    @(posedge TCK);
    #1;
    chk("midrst_state", 32'(tap_state), 32'(TLR));
    chk("midrst_tdo_en", 32'(tdo_en), 32'h0);
    chk("midrst_user_dr_out", user_dr_out, 32'h0);
    chk("midrst_ir_out", 32'(ir_out), 32'(c_reset_opc));
    Reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("midrst_pulse", pulse_cnt - p0, 0);
    chk("midrst_after_state", 32'(tap_state), 32'(RTI));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_tap_core.md
JTAG_TAP_CORE -- requirements
Module: jtag_tap_core

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width, minimum 2.
REQ-002 Parameter DR_WIDTH, default 32: user data register width, minimum 1.
REQ-003 Parameter IDCODE_VAL, default 32'h1234_5001: device ID; bit 0 SHALL be 1.
REQ-004 Parameter OPC_IDCODE, default 4'b0001, and parameter OPC_USER, default 4'b0010: instruction opcodes, each IR_WIDTH bits wide.
REQ-005 Port TCK, input, 1: the only clock; all logic is on the rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port TMS, input, 1: test mode select.
REQ-008 Port TDI, input, 1: serial data in.
REQ-009 Port TDO, output, 1: serial data out.
REQ-010 Port tdo_en, output, 1: TDO valid (pad output-enable).
REQ-011 Port tap_state, output, 4: current TAP state.
REQ-012 Port ir_out, output, IR_WIDTH: latched instruction.
REQ-013 Port user_dr_in, input, DR_WIDTH: capture value for USER.
REQ-014 Port user_dr_out, output, DR_WIDTH: value from the last USER update.
REQ-015 Port user_update, output, 1: one-cycle pulse on each USER Update-DR.

Function
REQ-016 The FSM SHALL implement all 16 IEEE 1149.1 states, with transitions driven by TMS sampled at each TCK rising edge.
REQ-017 From any state, 5 consecutive TMS=1 cycles SHALL reach Test-Logic-Reset.
REQ-018 The IR shift register SHALL load {0...0,01} (LSB = 1) on Capture-IR.
REQ-019 In Shift-IR, each cycle the IR shift register SHALL shift right, with TDI entering the MSB.
REQ-020 ir_out SHALL load the IR shift register on the cycle the FSM leaves Update-IR's predecessor into Update-IR, i.e. it is valid the cycle after entering Update-IR.
REQ-021 DR selection SHALL be: ir_out == OPC_IDCODE selects the 32-bit ID register; ir_out == OPC_USER selects the DR_WIDTH user register; all other values, including all-ones, select the 1-bit bypass register.
REQ-022 On Capture-DR, the selected register SHALL load as follows: ID register loads IDCODE_VAL; user register loads user_dr_in; bypass loads 0.
REQ-023 In Shift-DR, the selected register SHALL shift right with TDI entering its MSB; unselected registers SHALL hold.
REQ-024 In Update-DR with USER selected, user_dr_out SHALL load the user shift register and user_update SHALL pulse for exactly one cycle.
REQ-025 In Update-DR with any other instruction selected, user_update SHALL stay 0.
REQ-026 tdo_en SHALL be 1 exactly when tap_state is Shift-DR or Shift-IR.
REQ-027 TDO SHALL be the LSB of the active shift register when tdo_en is 1, and 0 otherwise.
REQ-028 Pause-DR and Pause-IR SHALL hold all shift registers unchanged.
REQ-029 A path through the Exit2 states back to Shift SHALL resume shifting without recapturing.

Reset
REQ-030 While Reset=1 at a TCK edge, the block SHALL force: state = Test-Logic-Reset; ir_out = reset opcode; user_dr_out = 0; user_update = 0; tdo_en = 0; all shift registers = 0.
REQ-031 Reset SHALL override TMS.
REQ-032 An asserted Reset mid-shift SHALL abort the shift; no Update is generated.
REQ-033 Entering Test-Logic-Reset through TMS SHALL also load ir_out with the reset opcode.
REQ-034 user_dr_out SHALL be preserved on a TMS-driven reset and cleared only by Reset.

Configuration
REQ-035 With macro JTAG_TAP_IDCODE_EN defined, the ID register SHALL exist and the reset opcode SHALL be OPC_IDCODE.
REQ-036 With JTAG_TAP_IDCODE_EN undefined, the ID register SHALL be absent, OPC_IDCODE SHALL decode as bypass, and the reset opcode SHALL be all-ones (BYPASS).

Structure
REQ-037 Package jtag_pkg SHALL hold the 4-bit state encoding constants: TLR=0, RTI=1, SELDR=2, CAPDR=3, SHDR=4, EX1DR=5, PDR=6, EX2DR=7, UPDR=8, SELIR=9, CAPIR=10, SHIR=11, EX1IR=12, PIR=13, EX2IR=14, UPIR=15.
REQ-038 The FSM SHALL be the sub-module jtag_tap_fsm, with ports TCK, Reset, TMS, and tap_state.
REQ-039 The register datapath SHALL reside in jtag_tap_core.

Verification
REQ-040 Reset test: Reset=1 for 2 cycles, then TMS=0 -> tap_state = TLR then RTI; ir_out = 4'b0001 (or 4'b1111 with the macro off).
REQ-041 IDCODE read: from RTI, TMS sequence 1,0,0 then 32 Shift-DR cycles -> TDO yields 32'h1234_5001 LSB first.
REQ-042 IR scan: load 4'b0010 via Shift-IR -> captured TDO pattern is 1,0,0,0; ir_out = 4'b0010 the cycle after entering UPIR.
REQ-043 USER round-trip: user_dr_in = 32'hCAFE_F00D; shift in 32'hA5A5_0F0F -> TDO yields CAFEF00D; user_dr_out = A5A50F0F; user_update high for exactly 1 cycle.
REQ-044 Bypass: IR = 4'b1111; shift in 1,0,1,1 -> TDO = 0,1,0,1 (one-cycle delay).
REQ-045 Escape: from Shift-DR, drive TMS=1 for 5 cycles -> tap_state = TLR; ir_out = reset opcode; user_dr_out unchanged.
